mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; the ports are listed below (name, direction, width, meaning).
REQ-002 clk  in  1  the single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 ex_valid  in  1  EX outputs valid this cycle.
REQ-005 mem_to_reg_in  in  1  load op from EX.
REQ-006 reg_to_mem_in  in  1  store op from EX.
REQ-007 ret_future_in  in  1  future ret_wb from EX.
REQ-008 reg_rd_in  in  4  regfile destination from EX.
REQ-009 alu_result_in  in  16  ALU result; the memory address for load/store.
REQ-010 store_data_in  in  16  store data.
REQ-011 stall_out  out  1  the upstream stage holds its outputs while this is high.
REQ-012 dmem_req  out  1  data memory request.
REQ-013 dmem_we  out  1  1 = write, 0 = read.
REQ-014 dmem_addr  out  16  memory address; dmem_wdata  out  16  write data.
REQ-015 dmem_rdata  in  16  read data; dmem_ack  in  1  request complete.
REQ-016 wb_valid  out  1; wb_data  out  16; wb_rd  out  4; ret_wb  out  1  writeback outputs.
REQ-017 dmem_err  out  1  sticky timeout flag.

Function
REQ-018 The FSM SHALL have the states IDLE, WAIT_RD and WAIT_WR; in IDLE with ex_valid high, it SHALL behave as follows:
- Store (reg_to_mem_in=1): capture address and data, go to WAIT_WR.
- Load (mem_to_reg_in=1 only): capture the address, go to WAIT_RD.
- Otherwise: writeback of alu_result_in on the next cycle.
REQ-019 If reg_to_mem_in and mem_to_reg_in are both high, the op SHALL be treated as a store.
REQ-020 dmem_req SHALL be registered: high from the first cycle in WAIT_* until the cycle dmem_ack is sampled high.
- dmem_addr, dmem_we and dmem_wdata are held stable throughout.
- dmem_we=1 only in WAIT_WR.
REQ-021 dmem_ack SHALL be ignored while dmem_req is low.
REQ-022 stall_out SHALL equal (state != IDLE), combinationally; ex_valid SHALL be ignored while stall_out is high.
REQ-023 Non-memory op: wb_valid SHALL pulse for exactly 1 cycle, the cycle after ex_valid, with wb_data = alu_result_in.
REQ-024 Load: on ack in WAIT_RD, wb_data SHALL register dmem_rdata.
- wb_valid pulses for 1 cycle, the cycle after ack.
- The FSM returns to IDLE on the same edge.
REQ-025 Store: on ack in WAIT_WR, the FSM SHALL return to IDLE; no wb_valid is produced.
REQ-026 wb_rd and ret_wb SHALL carry the captured reg_rd_in and ret_future_in, and are meaningful only when wb_valid is high.
REQ-027 Back-to-back operation: a new op SHALL be accepted in the first IDLE cycle after completion, giving minimum load/store occupancy of 2 cycles (ack on the first req cycle).
REQ-028 A 5-bit wait counter SHALL clear on entry to WAIT_* and increment each WAIT_* cycle without ack.
REQ-029 Timeout: on reaching TIMEOUT_CYCLES (16) without ack, the block SHALL:
- Drop dmem_req.
- Set dmem_err (sticky until reset).
- Return to IDLE; an aborted load produces wb_valid with wb_data=16'h0000.
REQ-030 An ack arriving in the same cycle as the timeout SHALL take precedence; the op completes normally.
REQ-031 No combinational path SHALL run from dmem_ack or dmem_rdata to any output.

Reset
REQ-032 On rst the module SHALL asynchronously force:
- State to IDLE, counter to 0.
- dmem_req, dmem_we, wb_valid, ret_wb and dmem_err to 0.
- dmem_addr, dmem_wdata, wb_data and wb_rd to 0.
REQ-033 Reset during WAIT_* SHALL abandon the transaction; a late ack after reset is ignored.

Structure
REQ-034 The package mem_stage_pkg SHALL hold the state enum typedef and the TIMEOUT_CYCLES constant.
REQ-035 The block SHALL be a single module with no sub-modules; FSM, counter and pipeline registers are inline.

Verification
REQ-036 ALU pass-through: ex_valid with alu_result_in=16'h1234, reg_rd_in=3 -> next cycle wb_valid=1, wb_data=16'h1234, wb_rd=3, stall_out=0 throughout.
REQ-037 Load, ack delay 3: addr 16'h0040 -> dmem_req high 3 cycles with addr 16'h0040 and we=0; rdata 16'hBEEF at ack -> wb_data=16'hBEEF one cycle later; stall_out high during the wait.
REQ-038 Store with both load and store flags high: addr 16'h0010, data 16'h00AA -> dmem_we=1, wdata=16'h00AA, no wb_valid.
REQ-039 Timeout: load with no ack -> dmem_req drops after 16 cycles, dmem_err=1, wb_valid with wb_data=0; ack sampled in cycle 16 -> normal completion, dmem_err=0.
REQ-040 Reset mid-WAIT_RD, then a stray ack -> all outputs 0, state IDLE, no wb_valid; ret_future_in=1 on an ALU op -> ret_wb=1 alongside wb_valid.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared state encoding and timing constants for the MEM pipeline stage.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_RD = 2'd1,
      ST_WAIT_WR = 2'd2
   } state_t;

   localparam int TIMEOUT_CYCLES = 16;
   localparam int CNT_W          = 5;

endpackage

// File: rtl/mem_stage.sv
// MEM stage: turns EX loads/stores into a req/ack data-memory handshake with a
// bounded wait, and forwards ALU results and load data to writeback.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        mem_to_reg_in,
   input  logic        reg_to_mem_in,
   input  logic        ret_future_in,
   input  logic [3:0]  reg_rd_in,
   input  logic [15:0] alu_result_in,
   input  logic [15:0] store_data_in,
   output logic        stall_out,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [15:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic [15:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        wb_valid,
   output logic [15:0] wb_data,
   output logic [3:0]  wb_rd,
   output logic        ret_wb,
   output logic        dmem_err
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_req;
   logic              r_we;
   logic [15:0]       r_addr;
   logic [15:0]       r_wdata;
   logic              r_wb_valid;
   logic [15:0]       r_wb_data;
   logic [3:0]        r_wb_rd;
   logic              r_ret_wb;
   logic              r_err;

   logic              w_accept;
   logic              w_ack;
   logic              w_timeout;

   // An ack only counts while a request is actually outstanding.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_timeout   = 1'b0;
      w_ack       = dmem_ack & r_req;
      case (r_state)
         ST_IDLE: begin
            if (ex_valid) begin
               w_accept = 1'b1;
               if (reg_to_mem_in)
                  w_state_nxt = ST_WAIT_WR;
               else if (mem_to_reg_in)
                  w_state_nxt = ST_WAIT_RD;
            end
         end
         ST_WAIT_RD, ST_WAIT_WR: begin
            if (w_ack) begin
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == CNT_LAST) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_req      <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wb_valid <= 1'b0;
         r_wb_data  <= '0;
         r_wb_rd    <= '0;
         r_ret_wb   <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_wb_valid <= 1'b0;
         if (w_accept) begin
            r_wb_rd  <= reg_rd_in;
            r_ret_wb <= ret_future_in;
            if (reg_to_mem_in) begin
               r_req   <= 1'b1;
               r_we    <= 1'b1;
               r_addr  <= alu_result_in;
               r_wdata <= store_data_in;
               r_cnt   <= '0;
            end else if (mem_to_reg_in) begin
               r_req  <= 1'b1;
               r_we   <= 1'b0;
               r_addr <= alu_result_in;
               r_cnt  <= '0;
            end else begin
               r_wb_valid <= 1'b1;
               r_wb_data  <= alu_result_in;
            end
         end else if (r_state != ST_IDLE) begin
            if (w_ack) begin
               r_req <= 1'b0;
               r_we  <= 1'b0;
               if (r_state == ST_WAIT_RD) begin
                  r_wb_valid <= 1'b1;
                  r_wb_data  <= dmem_rdata;
               end
            end else begin
               r_cnt <= r_cnt + 1'b1;
               // Abandoned loads still retire so the destination register sees a defined zero.
               if (w_timeout) begin
                  r_req <= 1'b0;
                  r_we  <= 1'b0;
                  r_err <= 1'b1;
                  if (r_state == ST_WAIT_RD) begin
                     r_wb_valid <= 1'b1;
                     r_wb_data  <= '0;
                  end
               end
            end
         end
      end
   end

   assign stall_out  = (r_state != ST_IDLE);
   assign dmem_req   = r_req;
   assign dmem_we    = r_we;
   assign dmem_addr  = r_addr;
   assign dmem_wdata = r_wdata;
   assign wb_valid   = r_wb_valid;
   assign wb_data    = r_wb_data;
   assign wb_rd      = r_wb_rd;
   assign ret_wb     = r_ret_wb;
   assign dmem_err   = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues directed and random ops, a
// memory responder plays the data memory, and a monitor checks writebacks.
module tb_mem_stage;

   logic        clk;
   logic        rst;
   logic        ex_valid;
   logic        mem_to_reg_in;
   logic        reg_to_mem_in;
   logic        ret_future_in;
   logic [3:0]  reg_rd_in;
   logic [15:0] alu_result_in;
   logic [15:0] store_data_in;
   logic        stall_out;
   logic        dmem_req;
   logic        dmem_we;
   logic [15:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic [15:0] dmem_rdata;
   logic        dmem_ack;
   logic        wb_valid;
   logic [15:0] wb_data;
   logic [3:0]  wb_rd;
   logic        ret_wb;
   logic        dmem_err;

   mem_stage dut (
      .clk           (clk),
      .rst           (rst),
      .ex_valid      (ex_valid),
      .mem_to_reg_in (mem_to_reg_in),
      .reg_to_mem_in (reg_to_mem_in),
      .ret_future_in (ret_future_in),
      .reg_rd_in     (reg_rd_in),
      .alu_result_in (alu_result_in),
      .store_data_in (store_data_in),
      .stall_out     (stall_out),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_rdata    (dmem_rdata),
      .dmem_ack      (dmem_ack),
      .wb_valid      (wb_valid),
      .wb_data       (wb_data),
      .wb_rd         (wb_rd),
      .ret_wb        (ret_wb),
      .dmem_err      (dmem_err)
   );

   typedef struct {
      logic [15:0] data;
      logic [3:0]  rd;
      logic        ret;
      int          cyc;
   } wb_t;

   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic [15:0] wdata;
      int          delay;
      logic [15:0] rdata;
      int          len;
      logic        err_after;
   } mem_t;

   wb_t  wq[$];
   mem_t mq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic err_m = 1'b0;
   logic resp_active = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Memory responder: acks the d-th request cycle, or never if d exceeds the timeout.
   initial begin
      mem_t cur;
      int   cnt;
      cnt = 0;
      cur = '{addr: 16'h0, we: 1'b0, wdata: 16'h0, delay: 1, rdata: 16'h0, len: 1, err_after: 1'b0};
      dmem_ack = 1'b0;
      dmem_rdata = 16'h0;
      forever begin
         @(negedge clk);
         if (rst) begin
            resp_active = 1'b0;
            dmem_ack = 1'b0;
            continue;
         end
         if (dmem_req) begin
            if (!resp_active) begin
               if (mq.size() == 0) begin
                  chk("unexpected_req", 32'd1, 32'd0);
                  cur = '{addr: dmem_addr, we: dmem_we, wdata: dmem_wdata, delay: 1, rdata: 16'h0, len: 1, err_after: dmem_err};
               end else begin
                  cur = mq.pop_front();
               end
               resp_active = 1'b1;
               cnt = 0;
            end
            cnt++;
            chk("dmem_addr", 32'(dmem_addr), 32'(cur.addr));
            chk("dmem_we", 32'(dmem_we), 32'(cur.we));
            if (cur.we) chk("dmem_wdata", 32'(dmem_wdata), 32'(cur.wdata));
            if (cnt == cur.delay) begin
               dmem_ack = 1'b1;
               dmem_rdata = cur.rdata;
            end else begin
               dmem_ack = 1'b0;
               dmem_rdata = 16'($urandom);
            end
         end else begin
            if (resp_active) begin
               chk("req_len", 32'(cnt), 32'(cur.len));
               chk("dmem_err", 32'(dmem_err), 32'(cur.err_after));
               resp_active = 1'b0;
            end
            dmem_ack = 1'($urandom_range(0, 1));
            dmem_rdata = 16'($urandom);
         end
      end
   end

   // Writeback monitor.
   initial begin
      wb_t e;
      forever begin
         @(negedge clk);
         if (rst) continue;
         chk("stall_vs_req", 32'(stall_out), 32'(dmem_req));
         if (wb_valid) begin
            if (wq.size() == 0) begin
               chk("unexpected_wb", 32'(wb_data), 32'hFFFF_FFFF);
            end else begin
               e = wq.pop_front();
               chk("wb_data", 32'(wb_data), 32'(e.data));
               chk("wb_rd", 32'(wb_rd), 32'(e.rd));
               chk("ret_wb", 32'(ret_wb), 32'(e.ret));
               chk("wb_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
      end
   end

   task automatic drive_junk();
      ex_valid      = 1'($urandom_range(0, 1));
      mem_to_reg_in = 1'($urandom_range(0, 1));
      reg_to_mem_in = 1'($urandom_range(0, 1));
      ret_future_in = 1'($urandom_range(0, 1));
      reg_rd_in     = 4'($urandom);
      alu_result_in = 16'($urandom);
      store_data_in = 16'($urandom);
   endtask

   // kind: 0 ALU, 1 load, 2 store, 3 load+store flags (treated as store)
   task automatic issue(input int kind, input logic [15:0] alu, input logic [15:0] sd,
                        input logic [3:0] rd, input logic ret, input int d, input logic [15:0] rdata);
      int   n;
      int   len;
      logic to;
      n = 0;
      @(negedge clk);
      while (stall_out && n < 100) begin
         drive_junk();
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("stall_bound", 32'd1, 32'd0);
      ex_valid      = 1'b1;
      mem_to_reg_in = (kind == 1 || kind == 3);
      reg_to_mem_in = (kind >= 2);
      ret_future_in = ret;
      reg_rd_in     = rd;
      alu_result_in = alu;
      store_data_in = sd;
      if (kind == 0) begin
         wq.push_back('{data: alu, rd: rd, ret: ret, cyc: cyc + 1});
      end else begin
         to  = (d > 16);
         len = to ? 16 : d;
         if (to) err_m = 1'b1;
         mq.push_back('{addr: alu, we: (kind >= 2), wdata: sd, delay: d, rdata: rdata,
                        len: len, err_after: err_m});
         if (kind == 1)
            wq.push_back('{data: (to ? 16'h0000 : rdata), rd: rd, ret: ret, cyc: cyc + 1 + len});
      end
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      ex_valid = 1'b0;
      alu_result_in = 16'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      ex_valid = 1'b0;
      while ((wq.size() != 0 || mq.size() != 0 || resp_active || stall_out) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_wb_left", 32'(wq.size()), 32'd0);
      chk("drain_mem_left", 32'(mq.size()), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_req"}, 32'(dmem_req), 32'd0);
      chk({tag, "_we"}, 32'(dmem_we), 32'd0);
      chk({tag, "_addr"}, 32'(dmem_addr), 32'd0);
      chk({tag, "_wdata"}, 32'(dmem_wdata), 32'd0);
      chk({tag, "_wbv"}, 32'(wb_valid), 32'd0);
      chk({tag, "_wbd"}, 32'(wb_data), 32'd0);
      chk({tag, "_wbrd"}, 32'(wb_rd), 32'd0);
      chk({tag, "_ret"}, 32'(ret_wb), 32'd0);
      chk({tag, "_err"}, 32'(dmem_err), 32'd0);
      chk({tag, "_stall"}, 32'(stall_out), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      int d;
      rst = 1'b1;
      ex_valid = 1'b0;
      mem_to_reg_in = 1'b0;
      reg_to_mem_in = 1'b0;
      ret_future_in = 1'b0;
      reg_rd_in = 4'h0;
      alu_result_in = 16'h0;
      store_data_in = 16'h0;
      repeat (2) @(negedge clk);
      check_all_zero("rst");
      #2 rst = 1'b0;

      // Directed: ALU pass-through, load with ack delay 3, store with both flags,
      // load acked in cycle 16, load timeout.
      issue(0, 16'h1234, 16'h0, 4'd3, 1'b0, 0, 16'h0);
      issue(1, 16'h0040, 16'h0, 4'd7, 1'b0, 3, 16'hBEEF);
      issue(3, 16'h0010, 16'h00AA, 4'd2, 1'b0, 2, 16'h0);
      issue(1, 16'h0050, 16'h0, 4'd9, 1'b1, 16, 16'hCAFE);
      drain();
      chk("err_after_ack16", 32'(dmem_err), 32'd0);
      issue(1, 16'h0060, 16'h0, 4'd4, 1'b0, 40, 16'h1111);
      drain();
      chk("err_after_timeout", 32'(dmem_err), 32'd1);

      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 9);
         d = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 24) : $urandom_range(1, 16);
         if (r < 2)
            idle_cycle();
         else if (r < 5)
            issue(0, 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 0, 16'h0);
         else if (r < 7)
            issue(1, 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), d, 16'($urandom));
         else
            issue((r == 9) ? 3 : 2, 16'($urandom), 16'($urandom), 4'($urandom),
                  1'($urandom_range(0, 1)), d, 16'($urandom));
      end
      drain();

      // Reset in the middle of a load wait, then stray acks must be ignored.
      issue(1, 16'h0abc, 16'h0, 4'd6, 1'b1, 40, 16'h2222);
      repeat (4) @(negedge clk);
      ex_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      wq.delete();
      mq.delete();
      err_m = 1'b0;
      @(negedge clk);
      check_all_zero("midrst");
      #2 rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("postrst_wbv", 32'(wb_valid), 32'd0);
         chk("postrst_req", 32'(dmem_req), 32'd0);
         chk("postrst_stall", 32'(stall_out), 32'd0);
      end
      issue(0, 16'h5a5a, 16'h0, 4'd5, 1'b1, 0, 16'h0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
